// File: rtl/test_final_bist_pkg.sv
// test_final_bist_pkg: shared widths, FSM states and LFSR/MISR polynomial constants for the BIST controller.
package test_final_bist_pkg;
  localparam int STIM_W = 15;
  localparam int RESP_W = 13;
  localparam int CNT_W = 16;
  localparam int LFSR_TAP_A = 14;
  localparam int LFSR_TAP_B = 13;
  localparam logic [STIM_W-1:0] SEED_ONE = STIM_W'(1);
  localparam logic [RESP_W-1:0] MISR_POLY = 13'h001B;
  typedef enum logic [2:0] {IDLE, SEED, APPLY, CAPTURE, DONE} state_t;
  function automatic logic [STIM_W-1:0] lfsr_next(input logic [STIM_W-1:0] l);
    return {l[STIM_W-2:0], l[LFSR_TAP_A] ^ l[LFSR_TAP_B]};
  endfunction
endpackage

// File: rtl/test_final_bist_misr.sv
// test_final_bist_misr: multiple-input signature register over x^13+x^4+x^3+x+1.
module test_final_bist_misr
  import test_final_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [RESP_W-1:0] din,
  output logic [RESP_W-1:0] sig
);
  always_ff @(posedge clk)
    if (rst || clr) sig <= '0;
    else if (en) sig <= {sig[RESP_W-2:0], 1'b0} ^ (sig[RESP_W-1] ? MISR_POLY : '0) ^ din;
endmodule

// File: rtl/test_final_bist.sv
// test_final_bist: LFSR-driven BIST controller; applies N patterns, compacts responses, compares to golden.
module test_final_bist
  import test_final_bist_pkg::*;
(
  input  logic              blif_clk_net,
  input  logic              blif_reset_net,
  input  logic              start,
  input  logic              abort,
  input  logic [STIM_W-1:0] seed,
  input  logic [CNT_W-1:0]  pat_count,
  input  logic [RESP_W-1:0] golden,
  input  logic [RESP_W-1:0] resp_in,
  output logic [STIM_W-1:0] stim_out,
  output logic              busy,
  output logic              done,
  output logic [RESP_W-1:0] signature,
  output logic              pass
);
  state_t state;
  logic [STIM_W-1:0] lfsr, seed_eff, lfsr_nxt;
  logic [CNT_W-1:0] cnt, n, cnt_nxt;
  logic kill;
  assign kill = abort && state inside {SEED, APPLY, CAPTURE};
  assign seed_eff = (seed == '0) ? SEED_ONE : seed;
  assign lfsr_nxt = lfsr_next(lfsr);
  assign cnt_nxt = cnt + CNT_W'(1);
  test_final_bist_misr u_misr (
    .clk(blif_clk_net),
    .rst(blif_reset_net),
    .clr(state == SEED && !abort),
    .en(state == CAPTURE && !abort),
    .din(resp_in),
    .sig(signature)
  );
  // Outputs are registered, so each transition loads the values of the state being entered.
  always_ff @(posedge blif_clk_net)
    if (blif_reset_net) begin
      state <= IDLE;
      lfsr <= '0;
      cnt <= '0;
      n <= '0;
      stim_out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        state <= IDLE;
        busy <= 1'b0;
        stim_out <= '0;
      end else
        case (state)
          IDLE: if (start && !abort) begin
            state <= SEED;
            n <= pat_count;
            busy <= 1'b1;
          end
          SEED: begin
            lfsr <= seed_eff;
            cnt <= '0;
            pass <= 1'b0;
            if (n != '0) begin
              state <= APPLY;
              stim_out <= seed_eff;
            end else begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
          APPLY: state <= CAPTURE;
          CAPTURE: begin
            lfsr <= lfsr_nxt;
            cnt <= cnt_nxt;
            if (cnt_nxt == n) begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
              stim_out <= '0;
            end else begin
              state <= APPLY;
              stim_out <= lfsr_nxt;
            end
          end
          DONE: begin
            state <= IDLE;
            pass <= (signature == golden);
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_test_final_bist.sv
// tb_test_final_bist: directed checks of the BIST controller against hand-computed values.
module tb_test_final_bist;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [14:0] seed = '0, stim_out;
  logic [15:0] pat_count = '0;
  logic [12:0] golden = '0, resp_in = '0, signature;
  logic busy, done, pass;
  int checks = 0, failures = 0;
  int done_cyc, ones, abort_at, rst_at, restart_at, snap_at;
  logic nz_seen;
  logic [14:0] last_stim;
  logic [14:0] stim_log [16];
  logic [31:0] snap;

  always #5 clk = ~clk;

  test_final_bist dut (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start), .abort(abort),
    .seed(seed), .pat_count(pat_count), .golden(golden), .resp_in(resp_in),
    .stim_out(stim_out), .busy(busy), .done(done), .signature(signature), .pass(pass)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycle c is the cycle after edge c-1, with start sampled at edge 0; APPLY cycles are the even ones.
  task automatic do_run(input logic [14:0] s, input logic [15:0] n, input int limit);
    seed = s;
    pat_count = n;
    done_cyc = -1;
    ones = 0;
    nz_seen = 1'b0;
    last_stim = '0;
    snap = '0;
    for (int i = 0; i < 16; i++) stim_log[i] = '0;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    for (int c = 1; c <= limit && done_cyc < 0; c++) begin
      @(negedge clk);
      if (stim_out != '0) nz_seen = 1'b1;
      if (c % 2 == 0 && !done) begin
        if (c / 2 - 1 < 16) stim_log[c/2-1] = stim_out;
        last_stim = stim_out;
        if (stim_out == 15'h0001) ones++;
      end
      if (c == snap_at) snap = {14'b0, busy, done, signature, pass, stim_out} >> 0;
      if (done) done_cyc = c;
      start = (c == restart_at);
      abort = (c == abort_at);
      rst = (c == rst_at);
    end
    start = 1'b0;
    abort = 1'b0;
    rst = 1'b0;
    abort_at = 0;
    rst_at = 0;
    restart_at = 0;
    snap_at = 0;
  endtask

  initial begin
    abort_at = 0; rst_at = 0; restart_at = 0; snap_at = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_stim", 32'(stim_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sig", 32'(signature), 0);
    check("rst_pass", 32'(pass), 0);

    golden = 13'h0000; resp_in = '0;
    do_run(15'h0001, 16'd3, 40);
    check("r1_done_cyc", 32'(done_cyc), 8);
    check("r1_stim0", 32'(stim_log[0]), 32'h1);
    check("r1_stim1", 32'(stim_log[1]), 32'h2);
    check("r1_stim2", 32'(stim_log[2]), 32'h4);
    check("r1_sig", 32'(signature), 0);
    @(negedge clk);
    check("r1_pass", 32'(pass), 1);
    check("r1_idle_busy", 32'(busy), 0);

    golden = 13'h0003; resp_in = 13'h0001;
    do_run(15'h0000, 16'd2, 40);
    check("r2_done_cyc", 32'(done_cyc), 6);
    check("r2_stim0", 32'(stim_log[0]), 32'h1);
    check("r2_stim1", 32'(stim_log[1]), 32'h2);
    check("r2_sig", 32'(signature), 32'h3);
    @(negedge clk);
    check("r2_pass", 32'(pass), 1);
    golden = 13'h0000;
    do_run(15'h0000, 16'd2, 40);
    @(negedge clk);
    check("r2_fail_pass", 32'(pass), 0);
    check("r2_sig_held", 32'(signature), 32'h3);

    resp_in = '0;
    do_run(15'h1234, 16'd0, 20);
    check("n0_done_cyc", 32'(done_cyc), 2);
    check("n0_sig", 32'(signature), 0);
    check("n0_stim_nz", 32'(nz_seen), 0);

    resp_in = 13'h0A5A;
    abort_at = 7; snap_at = 8;
    do_run(15'h0005, 16'd10, 40);
    check("ab_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    check("ab_stim2", 32'(stim_log[2]), 32'h14);
    check("ab_snap", snap, 0 | (32'(signature) << 16));
    check("ab_busy", 32'(busy), 0);
    resp_in = '0;
    do_run(15'h0001, 16'd3, 40);
    check("ab_rerun_cyc", 32'(done_cyc), 8);
    check("ab_rerun_stim2", 32'(stim_log[2]), 32'h4);
    @(negedge clk);
    check("ab_rerun_pass", 32'(pass), 1);

    rst_at = 2; snap_at = 3;
    do_run(15'h0001, 16'd5, 40);
    check("rs_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    check("rs_snap", snap, 0);
    check("rs_pass", 32'(pass), 0);

    restart_at = 4;
    do_run(15'h0001, 16'd3, 40);
    check("rb_done_cyc", 32'(done_cyc), 8);
    check("rb_stim2", 32'(stim_log[2]), 32'h4);
    repeat (3) @(negedge clk);
    check("rb_no_restart", 32'(busy), 0);

    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(posedge clk) #1 begin start = 1'b0; abort = 1'b0; end
    @(negedge clk);
    check("sa_idle", 32'(busy), 0);
    @(negedge clk);
    check("sa_idle2", 32'(busy), 0);

    do_run(15'h0001, 16'd32768, 65600);
    check("per_done_cyc", 32'(done_cyc), 65538);
    check("per_ones", 32'(ones), 2);
    check("per_last", 32'(last_stim), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
